// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side valid/ready handshake.
interface fetch_unit_if;
    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic [1:0]  fifo_count;

    modport master (
        output PC,
        output id_valid,
        output id_instr,
        output id_pc,
        output fifo_count,
        input  Instruction_Code,
        input  id_ready
    );

    modport slave (
        input  PC,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  fifo_count,
        output Instruction_Code,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register feeding a combinational instruction memory,
// with a 2-entry {pc, instr} FIFO toward decode, stall and redirect/flush support.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       bus
);

    localparam logic [31:0] ADDR_MASK = MEM_BYTES - 1;

    logic [31:0] pc_q;
    logic [31:0] entry_pc    [2];
    logic [31:0] entry_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        head_valid;

    assign head_valid = (count != 2'd0);
    assign pop        = head_valid & bus.id_ready;
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign push       = fetch_en & ~redirect_valid & ((count < 2'd2) | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q           <= RESET_PC;
            entry_pc[0]    <= 32'd0;
            entry_pc[1]    <= 32'd0;
            entry_instr[0] <= 32'd0;
            entry_instr[1] <= 32'd0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            count          <= 2'd0;
        end else if (redirect_valid) begin
            pc_q   <= redirect_pc & ~32'h3 & ADDR_MASK;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entry_pc[wr_ptr]    <= pc_q;
                entry_instr[wr_ptr] <= bus.Instruction_Code;
                wr_ptr              <= ~wr_ptr;
                pc_q                <= (pc_q + 32'd4) & ADDR_MASK;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign bus.PC         = pc_q;
    assign bus.id_valid   = head_valid;
    assign bus.id_instr   = entry_instr[rd_ptr];
    assign bus.id_pc      = entry_pc[rd_ptr];
    assign bus.fifo_count = count;

endmodule
